// File: rtl/uart_tx_pkt_if.sv
// -----------------------------------------------------------------------------
// uart_tx_pkt_if
// Bundles the command, sample and byte-stream signals of uart_tx_pkt.
// The packetiser is the slave; whatever drives commands and samples and
// sinks the byte stream is the master.
//
// Signals (direction as seen by the packetiser):
//   cmd_reg_i/cmd_vld_i             in   command code and one-cycle strobe
//   burst_cnt_i/burst_cnt_vld_i     in   burst sample count and strobe
//   abort_i                         in   message-error abort from the RX path
//   sample_i/sample_vld_i           in   N_CH*BYTES_PER_CH*8-bit sample, valid
//   sample_rdy_o                    out  sample accepted when vld && rdy
//   txd_byte_o/txd_byte_vld_o       out  byte towards the TX FIFO, valid
//   txd_byte_rdy_i                  in   TX FIFO not full
//   busy_o                          out  packetiser not idle
//   pkt_done_o                      out  one-cycle end-of-packet pulse
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

interface uart_tx_pkt_if #(
  parameter int N_CH         = 2,
  parameter int BYTES_PER_CH = 6
);
  logic [7:0]                      cmd_reg_i;
  logic                            cmd_vld_i;
  logic [7:0]                      burst_cnt_i;
  logic                            burst_cnt_vld_i;
  logic                            abort_i;
  logic [N_CH*BYTES_PER_CH*8-1:0]  sample_i;
  logic                            sample_vld_i;
  logic                            sample_rdy_o;
  logic [7:0]                      txd_byte_o;
  logic                            txd_byte_vld_o;
  logic                            txd_byte_rdy_i;
  logic                            busy_o;
  logic                            pkt_done_o;

  modport slave (
    input  cmd_reg_i, cmd_vld_i, burst_cnt_i, burst_cnt_vld_i, abort_i,
    input  sample_i, sample_vld_i, txd_byte_rdy_i,
    output sample_rdy_o, txd_byte_o, txd_byte_vld_o, busy_o, pkt_done_o
  );

  modport master (
    output cmd_reg_i, cmd_vld_i, burst_cnt_i, burst_cnt_vld_i, abort_i,
    output sample_i, sample_vld_i, txd_byte_rdy_i,
    input  sample_rdy_o, txd_byte_o, txd_byte_vld_o, busy_o, pkt_done_o
  );
endinterface

// File: rtl/uart_tx_pkt.sv
// -----------------------------------------------------------------------------
// uart_tx_pkt
// Builds command-driven sample packets and streams them one byte at a time
// into a UART TX FIFO.
//
//   single packet : HEADER, CMD_SINGLE, D data bytes, CRC
//   burst packet  : HEADER, CMD_BURST, count, count x D data bytes, CRC
//   D = N_CH * BYTES_PER_CH; data is channel 0 first, LSB first per channel.
//   CRC-8 (MSB-first, POLY, init CRC_INIT, no final XOR) covers HEADER
//   through the last data byte.
//
// Ports:
//   clk_i   in  clock, all logic on the rising edge
//   rst_i   in  synchronous active-high reset
//   bus     uart_tx_pkt_if.slave (command, sample, byte stream, status)
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module uart_tx_pkt #(
  parameter int         N_CH         = 2,
  parameter int         BYTES_PER_CH = 6,
  parameter logic [7:0] HEADER       = 8'hA5,
  parameter logic [7:0] POLY         = 8'h07,
  parameter logic [7:0] CRC_INIT     = 8'h00,
  parameter logic [7:0] CMD_SINGLE   = 8'h01,
  parameter logic [7:0] CMD_BURST    = 8'h02
) (
  input  logic          clk_i,
  input  logic          rst_i,
  uart_tx_pkt_if.slave  bus
);

  localparam int D  = N_CH * BYTES_PER_CH;
  localparam int SW = D * 8;
  localparam int IW = (D > 1) ? $clog2(D) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARMED,
    S_HDR,
    S_CMD,
    S_CNT,
    S_DATA,
    S_WAIT_S,
    S_CRC
  } state_t;

  // One full byte of CRC-8 in a single cycle: the loop unrolls into XOR logic.
  function automatic logic [7:0] crc8_next(input logic [7:0] crc,
                                           input logic [7:0] data);
    logic [7:0] c;
    c = crc ^ data;
    for (int i = 0; i < 8; i++) begin
      c = c[7] ? ((c << 1) ^ POLY) : (c << 1);
    end
    return c;
  endfunction

  state_t          r_state;
  state_t          w_nxt;
  logic [7:0]      r_cmd;
  logic [7:0]      r_cnt;       // latched burst count, also sent as count byte
  logic [7:0]      r_rem;       // samples still to come after the current one
  logic [IW-1:0]   r_byte_idx;  // data byte index within the current sample
  logic [SW-1:0]   r_buf;
  logic [7:0]      r_crc;
  logic            r_done;

  logic [7:0]      w_byte;
  logic [7:0]      w_data_byte;
  logic            w_vld;
  logic            w_srdy;
  logic            w_xfer;
  logic            w_accept;
  logic            w_cmd_ok;
  logic            w_cfg_win;
  logic            w_last;
  logic            w_is_burst;

  assign w_xfer     = w_vld && bus.txd_byte_rdy_i;
  assign w_accept   = w_srdy && bus.sample_vld_i;
  assign w_cmd_ok   = bus.cmd_vld_i &&
                      ((bus.cmd_reg_i == CMD_SINGLE) || (bus.cmd_reg_i == CMD_BURST));
  // Commands and burst counts are only taken before a packet starts.
  assign w_cfg_win  = (r_state == S_IDLE) || (r_state == S_ARMED);
  assign w_last     = (r_byte_idx == IW'(D - 1));
  assign w_is_burst = (r_cmd == CMD_BURST);

  // Data byte mux: buffer byte k is channel k/BYTES_PER_CH, byte k%BYTES_PER_CH,
  // so linear order already gives channel 0 first, LSB first.
  always_comb begin
    w_data_byte = 8'h00;
    for (int k = 0; k < D; k++) begin
      if (r_byte_idx == IW'(k)) begin
        w_data_byte = r_buf[k*8 +: 8];
      end
    end
  end

  // Next state and outputs; outputs depend on state and registers only, so
  // byte and valid stay fixed while the FIFO stalls.
  always_comb begin
    w_nxt  = r_state;
    w_byte = 8'h00;
    w_vld  = 1'b0;
    w_srdy = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_cmd_ok) w_nxt = S_ARMED;
      end
      S_ARMED: begin
        w_srdy = 1'b1;
        if (w_accept) w_nxt = S_HDR;
      end
      S_HDR: begin
        w_vld  = 1'b1;
        w_byte = HEADER;
        if (w_xfer) w_nxt = S_CMD;
      end
      S_CMD: begin
        w_vld  = 1'b1;
        w_byte = r_cmd;
        if (w_xfer) w_nxt = w_is_burst ? S_CNT : S_DATA;
      end
      S_CNT: begin
        w_vld  = 1'b1;
        w_byte = r_cnt;
        if (w_xfer) w_nxt = (r_cnt == 8'd0) ? S_CRC : S_DATA;
      end
      S_DATA: begin
        w_vld  = 1'b1;
        w_byte = w_data_byte;
        if (w_xfer && w_last) begin
          w_nxt = (w_is_burst && (r_rem != 8'd0)) ? S_WAIT_S : S_CRC;
        end
      end
      S_WAIT_S: begin
        w_srdy = 1'b1;
        if (w_accept) w_nxt = S_DATA;
      end
      S_CRC: begin
        w_vld  = 1'b1;
        w_byte = r_crc;
        if (w_xfer) w_nxt = S_IDLE;
      end
      default: w_nxt = S_IDLE;
    endcase
    if (bus.abort_i) w_nxt = S_IDLE;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state    <= S_IDLE;
      r_cmd      <= 8'h00;
      r_cnt      <= 8'h00;
      r_rem      <= 8'h00;
      r_byte_idx <= '0;
      r_buf      <= '0;
      r_crc      <= CRC_INIT;
      r_done     <= 1'b0;
    end else if (bus.abort_i) begin
      // Abort beats any simultaneous command, accept or byte transfer.
      r_state    <= S_IDLE;
      r_cnt      <= 8'h00;
      r_rem      <= 8'h00;
      r_byte_idx <= '0;
      r_crc      <= CRC_INIT;
      r_done     <= 1'b0;
    end else begin
      r_state <= w_nxt;
      r_done  <= (r_state == S_CRC) && w_xfer;

      if (w_cmd_ok && w_cfg_win)           r_cmd <= bus.cmd_reg_i;
      if (bus.burst_cnt_vld_i && w_cfg_win) r_cnt <= bus.burst_cnt_i;

      if (w_accept) begin
        r_buf      <= bus.sample_i;
        r_byte_idx <= '0;
      end

      if (w_xfer) begin
        case (r_state)
          S_HDR, S_CMD: r_crc <= crc8_next(r_crc, w_byte);
          S_CNT: begin
            r_crc <= crc8_next(r_crc, w_byte);
            r_rem <= (r_cnt == 8'd0) ? 8'd0 : r_cnt - 8'd1;
          end
          S_DATA: begin
            r_crc <= crc8_next(r_crc, w_byte);
            if (w_last) begin
              r_byte_idx <= '0;
              if (w_is_burst && (r_rem != 8'd0)) r_rem <= r_rem - 8'd1;
            end else begin
              r_byte_idx <= r_byte_idx + IW'(1);
            end
          end
          S_CRC: r_crc <= CRC_INIT;
          default: ;
        endcase
      end
    end
  end

  assign bus.txd_byte_o     = w_byte;
  assign bus.txd_byte_vld_o = w_vld;
  assign bus.sample_rdy_o   = w_srdy;
  assign bus.busy_o         = (r_state != S_IDLE);
  assign bus.pkt_done_o     = r_done;

endmodule

// File: tb/tb_uart_tx_pkt.sv
`timescale 1ns/1ps

module tb_uart_tx_pkt;
  localparam logic [7:0] POLY = 8'h07;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  uart_tx_pkt_if #(.N_CH(1), .BYTES_PER_CH(1)) bs();
  uart_tx_pkt_if bd();

  uart_tx_pkt #(.N_CH(1), .BYTES_PER_CH(1)) u_small (.clk_i(clk), .rst_i(rst), .bus(bs));
  uart_tx_pkt u_dut (.clk_i(clk), .rst_i(rst), .bus(bd));

  int errors = 0;
  int checks = 0;
  logic [7:0] q_s[$];
  logic [7:0] q_d[$];
  int nbytes_s = 0;
  int nbytes_d = 0;
  bit rand_rdy = 1'b0;
  bit pend = 1'b0;
  logic [7:0] pend_byte = 8'h00;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Golden CRC-8, bit-serial MSB-first form.
  function automatic logic [7:0] gcrc(input logic [7:0] crc, input logic [7:0] d);
    logic [7:0] c;
    bit fb;
    c = crc;
    for (int i = 7; i >= 0; i--) begin
      fb = c[7] ^ d[i];
      c  = {c[6:0], 1'b0};
      if (fb) c = c ^ POLY;
    end
    return c;
  endfunction

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic push_d(input logic [7:0] b, inout logic [7:0] crc);
    q_d.push_back(b);
    crc = gcrc(crc, b);
  endtask

  task automatic push_sample_d(input logic [95:0] s, inout logic [7:0] crc);
    for (int b = 0; b < 12; b++) push_d(s[b*8 +: 8], crc);
  endtask

  task automatic send_sample_d(input logic [95:0] s, output bit ok);
    bd.sample_i = s;
    bd.sample_vld_i = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge clk);
      if (bd.sample_rdy_o) ok = 1'b1;
      tick();
    end
    bd.sample_vld_i = 1'b0;
  endtask

  task automatic wait_done_d(output bit ok, output bit saw_rdy);
    ok = 1'b0;
    saw_rdy = 1'b0;
    for (int i = 0; i < 600 && !ok; i++) begin
      @(negedge clk);
      if (bd.sample_rdy_o) saw_rdy = 1'b1;
      if (bd.pkt_done_o) ok = 1'b1;
    end
  endtask

  task automatic strobe_cmd_d(input logic [7:0] cmd, input bit with_cnt, input logic [7:0] cnt);
    bd.cmd_reg_i = cmd;
    bd.cmd_vld_i = 1'b1;
    bd.burst_cnt_i = cnt;
    bd.burst_cnt_vld_i = with_cnt;
    tick();
    bd.cmd_vld_i = 1'b0;
    bd.burst_cnt_vld_i = 1'b0;
  endtask

  task automatic mon_d();
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (pend) begin
          chk("stall_hold_vld", 32'(bd.txd_byte_vld_o), 32'd1);
          chk("stall_hold_byte", 32'(bd.txd_byte_o), 32'(pend_byte));
        end
        if (bd.txd_byte_vld_o && bd.txd_byte_rdy_i) begin
          nbytes_d++;
          if (q_d.size() == 0) begin
            checks++;
            errors++;
            $error("FAIL unexpected_byte_d observed=%0h expected=none", bd.txd_byte_o);
          end else begin
            chk("byte_d", 32'(bd.txd_byte_o), 32'(q_d.pop_front()));
          end
        end
        pend = bd.txd_byte_vld_o && !bd.txd_byte_rdy_i;
        pend_byte = bd.txd_byte_o;
      end else begin
        pend = 1'b0;
      end
    end
  endtask

  task automatic mon_s();
    forever begin
      @(negedge clk);
      if (!rst && bs.txd_byte_vld_o && bs.txd_byte_rdy_i) begin
        nbytes_s++;
        if (q_s.size() == 0) begin
          checks++;
          errors++;
          $error("FAIL unexpected_byte_s observed=%0h expected=none", bs.txd_byte_o);
        end else begin
          chk("byte_s", 32'(bs.txd_byte_o), 32'(q_s.pop_front()));
        end
      end
    end
  endtask

  task automatic rdy_drv();
    forever begin
      @(posedge clk); #1;
      bd.txd_byte_rdy_i = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  endtask

  task automatic chk_reset_outs(input string tag);
    chk({tag, "_byte"}, 32'(bd.txd_byte_o), 32'h00);
    chk({tag, "_vld"},  32'(bd.txd_byte_vld_o), 32'd0);
    chk({tag, "_srdy"}, 32'(bd.sample_rdy_o), 32'd0);
    chk({tag, "_busy"}, 32'(bd.busy_o), 32'd0);
    chk({tag, "_done"}, 32'(bd.pkt_done_o), 32'd0);
  endtask

  initial begin
    logic [7:0]  crc;
    logic [95:0] smp;
    bit ok, saw;
    int n0;

    bs.cmd_reg_i = 8'h00; bs.cmd_vld_i = 1'b0; bs.burst_cnt_i = 8'h00;
    bs.burst_cnt_vld_i = 1'b0; bs.abort_i = 1'b0; bs.sample_i = '0;
    bs.sample_vld_i = 1'b0; bs.txd_byte_rdy_i = 1'b1;
    bd.cmd_reg_i = 8'h00; bd.cmd_vld_i = 1'b0; bd.burst_cnt_i = 8'h00;
    bd.burst_cnt_vld_i = 1'b0; bd.abort_i = 1'b0; bd.sample_i = '0;
    bd.sample_vld_i = 1'b0; bd.txd_byte_rdy_i = 1'b1;

    fork
      mon_d();
      mon_s();
      rdy_drv();
    join_none

    // Reset state
    repeat (3) tick();
    @(negedge clk);
    chk_reset_outs("reset");
    tick();
    rst = 1'b0;

    // Minimal single packet: A5,01,00,9D back to back, then done pulse
    q_s.push_back(8'hA5); q_s.push_back(8'h01); q_s.push_back(8'h00); q_s.push_back(8'h9D);
    bs.cmd_reg_i = 8'h01; bs.cmd_vld_i = 1'b1;
    tick();
    bs.cmd_vld_i = 1'b0;
    @(negedge clk);
    chk("s_armed_busy", 32'(bs.busy_o), 32'd1);
    chk("s_armed_rdy", 32'(bs.sample_rdy_o), 32'd1);
    bs.sample_i = '0; bs.sample_vld_i = 1'b1;
    tick();
    bs.sample_vld_i = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("s_vld_cycle", 32'(bs.txd_byte_vld_o), 32'd1);
      tick();
    end
    @(negedge clk);
    chk("s_done", 32'(bs.pkt_done_o), 32'd1);
    chk("s_idle", 32'(bs.busy_o), 32'd0);
    tick();
    @(negedge clk);
    chk("s_done_once", 32'(bs.pkt_done_o), 32'd0);
    chk("s_q_empty", 32'(q_s.size()), 32'd0);
    chk("s_nbytes", 32'(nbytes_s), 32'd4);
    tick();

    // Burst of 3 samples with random FIFO stalls
    n0 = nbytes_d;
    crc = 8'h00;
    strobe_cmd_d(8'h02, 1'b1, 8'd3);
    push_d(8'hA5, crc); push_d(8'h02, crc); push_d(8'h03, crc);
    rand_rdy = 1'b1;
    for (int s = 0; s < 3; s++) begin
      smp = {$urandom(), $urandom(), $urandom()};
      push_sample_d(smp, crc);
      if (s == 2) q_d.push_back(crc);
      send_sample_d(smp, ok);
      chk("b_accept", 32'(ok), 32'd1);
    end
    wait_done_d(ok, saw);
    chk("b_done", 32'(ok), 32'd1);
    rand_rdy = 1'b0;
    chk("b_nbytes", 32'(nbytes_d - n0), 32'd40);
    chk("b_q_empty", 32'(q_d.size()), 32'd0);
    tick(); tick();

    // Burst count 0: header, cmd, count, CRC only
    n0 = nbytes_d;
    crc = 8'h00;
    strobe_cmd_d(8'h02, 1'b1, 8'd0);
    push_d(8'hA5, crc); push_d(8'h02, crc); push_d(8'h00, crc);
    q_d.push_back(crc);
    smp = {$urandom(), $urandom(), $urandom()};
    send_sample_d(smp, ok);
    chk("c_accept", 32'(ok), 32'd1);
    wait_done_d(ok, saw);
    chk("c_done", 32'(ok), 32'd1);
    chk("c_no_rdy", 32'(saw), 32'd0);
    chk("c_nbytes", 32'(nbytes_d - n0), 32'd4);
    chk("c_q_empty", 32'(q_d.size()), 32'd0);
    tick();

    // Abort on the 5th data byte, then a clean single packet
    n0 = nbytes_d;
    crc = 8'h00;
    strobe_cmd_d(8'h01, 1'b0, 8'd0);
    smp = {$urandom(), $urandom(), $urandom()};
    push_d(8'hA5, crc); push_d(8'h01, crc);
    for (int b = 0; b < 5; b++) push_d(smp[b*8 +: 8], crc);
    send_sample_d(smp, ok);
    chk("d_accept", 32'(ok), 32'd1);
    repeat (6) tick();
    @(negedge clk);
    chk("d_5th_vld", 32'(bd.txd_byte_vld_o), 32'd1);
    chk("d_5th_byte", 32'(bd.txd_byte_o), 32'(smp[39:32]));
    bd.abort_i = 1'b1;
    tick();
    bd.abort_i = 1'b0;
    @(negedge clk);
    chk("d_abort_vld", 32'(bd.txd_byte_vld_o), 32'd0);
    chk("d_abort_busy", 32'(bd.busy_o), 32'd0);
    chk("d_abort_done", 32'(bd.pkt_done_o), 32'd0);
    chk("d_abort_q", 32'(q_d.size()), 32'd0);
    chk("d_abort_nbytes", 32'(nbytes_d - n0), 32'd7);
    tick();
    n0 = nbytes_d;
    crc = 8'h00;
    strobe_cmd_d(8'h01, 1'b0, 8'd0);
    smp = {$urandom(), $urandom(), $urandom()};
    push_d(8'hA5, crc); push_d(8'h01, crc);
    push_sample_d(smp, crc);
    q_d.push_back(crc);
    send_sample_d(smp, ok);
    wait_done_d(ok, saw);
    chk("d2_done", 32'(ok), 32'd1);
    chk("d2_nbytes", 32'(nbytes_d - n0), 32'd15);
    chk("d2_q_empty", 32'(q_d.size()), 32'd0);
    tick();

    // Unknown command ignored; command during DATA ignored
    bd.cmd_reg_i = 8'h7F; bd.cmd_vld_i = 1'b1;
    tick();
    bd.cmd_vld_i = 1'b0;
    @(negedge clk);
    chk("e_badcmd_busy", 32'(bd.busy_o), 32'd0);
    chk("e_badcmd_srdy", 32'(bd.sample_rdy_o), 32'd0);
    tick();
    n0 = nbytes_d;
    crc = 8'h00;
    strobe_cmd_d(8'h01, 1'b0, 8'd0);
    smp = {$urandom(), $urandom(), $urandom()};
    push_d(8'hA5, crc); push_d(8'h01, crc);
    push_sample_d(smp, crc);
    q_d.push_back(crc);
    send_sample_d(smp, ok);
    repeat (4) tick();
    strobe_cmd_d(8'h02, 1'b1, 8'd5);
    wait_done_d(ok, saw);
    chk("e_done", 32'(ok), 32'd1);
    chk("e_nbytes", 32'(nbytes_d - n0), 32'd15);
    chk("e_q_empty", 32'(q_d.size()), 32'd0);
    tick();
    @(negedge clk);
    chk("e_not_rearmed", 32'(bd.busy_o), 32'd0);
    tick();

    // Reset while waiting for the next burst sample
    n0 = nbytes_d;
    crc = 8'h00;
    strobe_cmd_d(8'h02, 1'b1, 8'd2);
    smp = {$urandom(), $urandom(), $urandom()};
    push_d(8'hA5, crc); push_d(8'h02, crc); push_d(8'h02, crc);
    push_sample_d(smp, crc);
    send_sample_d(smp, ok);
    ok = 1'b0;
    for (int i = 0; i < 100 && !ok; i++) begin
      @(negedge clk);
      if (bd.sample_rdy_o) ok = 1'b1;
    end
    chk("f_wait_s", 32'(ok), 32'd1);
    chk("f_wait_busy", 32'(bd.busy_o), 32'd1);
    chk("f_wait_vld", 32'(bd.txd_byte_vld_o), 32'd0);
    rst = 1'b1;
    tick();
    @(negedge clk);
    chk_reset_outs("f_rst");
    rst = 1'b0;
    repeat (5) tick();
    @(negedge clk);
    chk("f_after_vld", 32'(bd.txd_byte_vld_o), 32'd0);
    chk("f_q_empty", 32'(q_d.size()), 32'd0);
    chk("f_nbytes", 32'(nbytes_d - n0), 32'd15);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/uart_tx_pkt.md
UART_TX_PKT -- requirements
Module: uart_tx_pkt

Interface
REQ-001 Parameter N_CH, default 2, channel count per sample, range 1..4.
REQ-002 Parameter BYTES_PER_CH, default 6, bytes per channel, range 1..8.
REQ-003 Parameter HEADER, default 8'hA5, first byte of every packet.
REQ-004 Parameter POLY, default 8'h07, CRC-8 polynomial; parameter CRC_INIT, default 8'h00, CRC start value.
REQ-005 Parameters CMD_SINGLE, default 8'h01, and CMD_BURST, default 8'h02, recognised command codes.
REQ-006 One clock; reset is synchronous and active-high.
REQ-007 clk_i  in  1  clock, all logic on rising edge.
REQ-008 rst_i  in  1  synchronous active-high reset.
REQ-009 cmd_reg_i  in  8  command code; cmd_vld_i  in  1  one-cycle command strobe.
REQ-010 burst_cnt_i  in  8  burst sample count; burst_cnt_vld_i  in  1  count strobe.
REQ-011 abort_i  in  1  message-error abort from the receive path.
REQ-012 sample_i  in  N_CH*BYTES_PER_CH*8  channel c in bits [c*BYTES_PER_CH*8 +: BYTES_PER_CH*8].
REQ-013 sample_vld_i  in  1  sample valid; sample_rdy_o  out  1  sample accepted when vld&&rdy.
REQ-014 txd_byte_o  out  8  byte to TX FIFO; txd_byte_vld_o  out  1  valid; txd_byte_rdy_i  in  1  FIFO not full.
REQ-015 busy_o  out  1  state != IDLE; pkt_done_o  out  1  one-cycle end-of-packet pulse.

Function
REQ-016 Let D = N_CH*BYTES_PER_CH; single packet = HEADER, CMD_SINGLE, D data bytes, CRC.
REQ-017 Burst packet = HEADER, CMD_BURST, count byte, count x D data bytes, CRC; count 0 yields no data bytes.
REQ-018 Data byte order: channel 0 first; within a channel, least significant byte first.
REQ-019 CRC: CRC-8, MSB-first, non-reflected, POLY, init CRC_INIT, no final XOR, over HEADER through last data byte; one byte per cycle (parallel update, no multi-cycle LFSR).
REQ-020 States: IDLE, ARMED, HDR, CMD, CNT, DATA, WAIT_S, CRC.
REQ-021 IDLE: cmd_vld_i with CMD_SINGLE or CMD_BURST -> ARMED, command latched; other codes ignored.
REQ-022 burst_cnt_vld_i in IDLE or ARMED latches burst_cnt_i; ignored in all other states.
REQ-023 ARMED: sample_rdy_o=1; new valid command re-latches command and stays ARMED; sample accept -> HDR, sample captured to buffer.
REQ-024 Sample accepted at cycle t -> HEADER presented with txd_byte_vld_o=1 at t+1.
REQ-025 Byte transfer occurs only on txd_byte_vld_o && txd_byte_rdy_i; byte and valid held stable until transfer.
REQ-026 Transfer sequence: HDR -> CMD -> (burst: CNT) -> DATA -> CRC; burst count 0 goes CNT -> CRC.
REQ-027 With txd_byte_rdy_i constantly 1, one byte per cycle, no bubbles within a sample.
REQ-028 Burst: after last byte of a sample, remaining count > 0 -> WAIT_S (sample_rdy_o=1, txd_byte_vld_o=0); accept -> DATA next cycle.
REQ-029 CRC register updated on each transfer; CRC byte equals register value after last data byte.
REQ-030 CRC byte transfer -> IDLE; pkt_done_o=1 in the following cycle only.
REQ-031 sample_rdy_o=0 in all states except ARMED and WAIT_S; cmd_vld_i ignored outside IDLE/ARMED.
REQ-032 abort_i in any state: next cycle IDLE, txd_byte_vld_o=0, CRC reloaded, counters cleared; abort wins over simultaneous cmd_vld_i or sample accept.
REQ-033 Aborted packet is not completed or resent; pkt_done_o not asserted.

Reset
REQ-034 rst_i=1: state IDLE, txd_byte_o=8'h00, txd_byte_vld_o=0, sample_rdy_o=0, busy_o=0, pkt_done_o=0, CRC=CRC_INIT, burst count=0, sample buffer=0.
REQ-035 Reset mid-packet has the same effect as REQ-034; no further bytes of that packet emitted.

Verification
REQ-036 N_CH=1, BYTES_PER_CH=1, cmd 8'h01, sample 8'h00, rdy=1 -> bytes A5,01,00,9D on 4 consecutive cycles, pkt_done_o pulse next cycle.
REQ-037 Defaults, burst count 3, three samples, random rdy stalls -> 2+1+36+1=40 bytes, order per REQ-018, CRC matches golden model, bytes stable during stalls.
REQ-038 Burst count 0 -> A5,02,00,CRC; sample_rdy_o never asserted after ARMED sample.
REQ-039 abort_i on 5th data byte -> txd_byte_vld_o=0 next cycle, busy_o=0, next single packet correct from CRC_INIT.
REQ-040 cmd 8'h7F in IDLE -> no state change; cmd_vld_i during DATA -> ignored, packet unchanged.
REQ-041 rst_i asserted in WAIT_S -> all outputs at REQ-034 values next cycle.
